// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: pops DATA_WIDTH lanes and packs PACK_N of them into one
// valid/ready output word; flush emits a partial word so tail bytes never stall.
module fifo_rd_packer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PACK_N     = 2
) (
    input  logic                                 rclk,
    input  logic                                 rrst_n,
    input  logic                                 rempty,
    input  logic [DATA_WIDTH-1:0]                rdata,
    output logic                                 rinc,
    input  logic                                 flush,
    output logic [DATA_WIDTH*PACK_N-1:0]         out_data,
    output logic [$clog2(PACK_N+1)-1:0]          out_bytes,
    output logic                                 out_valid,
    input  logic                                 out_ready
);

    localparam int unsigned CNT_W  = $clog2(PACK_N + 1);
    localparam int unsigned WORD_W = DATA_WIDTH * PACK_N;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PACK_N - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PACK_N);

    typedef enum logic {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [CNT_W-1:0]    bytes_q, bytes_d;
    logic                valid_q, valid_d;
    logic                pop;

    // Pop strobe is combinational so the FIFO sees it in the same cycle it is decided.
    assign rinc = rrst_n & (state_q == S_FILL) & ~rempty;
    assign pop  = rinc;

    assign out_data  = word_q;
    assign out_bytes = bytes_q;
    assign out_valid = valid_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            word_q  <= '0;
            bytes_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            bytes_q <= bytes_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        bytes_d = bytes_q;
        valid_d = valid_q;

        case (state_q)
            S_FILL: begin
                if (pop) begin
                    for (int unsigned i = 0; i < PACK_N; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            word_d[i*DATA_WIDTH +: DATA_WIDTH] = rdata;
                        end
                    end
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_HOLD;
                        bytes_d = CNT_FULL;
                        valid_d = 1'b1;
                    end else if (flush) begin
                        // Byte popped alongside flush is part of the emitted word.
                        state_d = S_HOLD;
                        bytes_d = cnt_q + CNT_W'(1);
                        valid_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (flush && (cnt_q != '0)) begin
                    state_d = S_HOLD;
                    bytes_d = cnt_q;
                    valid_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (valid_q && out_ready) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    word_d  = '0;
                    bytes_d = '0;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_FILL;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: PACK_N=2 and PACK_N=4 instances fed by a
// queue-based first-word-fall-through FIFO model.
module tb_fifo_rd_packer;

    logic        rclk   = 1'b0;
    logic        rrst_n = 1'b1;

    logic        rempty2 = 1'b1, flush2 = 1'b0, out_ready2 = 1'b0;
    logic [7:0]  rdata2 = '0;
    logic        rinc2, out_valid2;
    logic [15:0] out_data2;
    logic [1:0]  out_bytes2;

    logic        rempty4 = 1'b1, flush4 = 1'b0, out_ready4 = 1'b0;
    logic [7:0]  rdata4 = '0;
    logic        rinc4, out_valid4;
    logic [31:0] out_data4;
    logic [2:0]  out_bytes4;

    logic [7:0]  q2[$];
    logic [7:0]  q4[$];
    logic [17:0] got2[$];
    int          pops2 = 0;
    int          pops4 = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 rclk = ~rclk;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_N(2)) u_dut2 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty2), .rdata(rdata2), .rinc(rinc2),
        .flush(flush2), .out_data(out_data2), .out_bytes(out_bytes2),
        .out_valid(out_valid2), .out_ready(out_ready2)
    );

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_N(4)) u_dut4 (
        .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty4), .rdata(rdata4), .rinc(rinc4),
        .flush(flush4), .out_data(out_data4), .out_bytes(out_bytes4),
        .out_valid(out_valid4), .out_ready(out_ready4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        rempty2 = (q2.size() == 0);
        rdata2  = (q2.size() != 0) ? q2[0] : 8'h00;
        rempty4 = (q4.size() == 0);
        rdata4  = (q4.size() != 0) ? q4[0] : 8'h00;
    endtask

    // One rclk edge: sample pop strobes and handshakes at the edge, then update the FIFO model.
    task automatic tick();
        logic p2, p4;
        @(posedge rclk);
        p2 = rinc2;
        p4 = rinc4;
        if (out_valid2 && out_ready2) got2.push_back({out_bytes2, out_data2});
        #1;
        if (p2) begin
            void'(q2.pop_front());
            pops2++;
        end
        if (p4) begin
            void'(q4.pop_front());
            pops4++;
        end
        refresh();
    endtask

    initial begin
        int base;
        int budget;
        logic [17:0] w;

        // Reset with data waiting: nothing may be popped or presented.
        #1 rrst_n = 1'b0;
        q2.push_back(8'hFF);
        refresh();
        #2;
        check_eq("rst_rinc", 32'(rinc2), 32'd0);
        check_eq("rst_valid", 32'(out_valid2), 32'd0);
        check_eq("rst_data", 32'(out_data2), 32'h0000);
        check_eq("rst_bytes", 32'(out_bytes2), 32'd0);
        tick();
        check_eq("rst_nopop", 32'(pops2), 32'd0);
        q2.delete();
        refresh();
        tick();
        rrst_n = 1'b1;

        // Basic pack
        out_ready2 = 1'b1;
        q2.push_back(8'h11); q2.push_back(8'h22);
        refresh();
        tick();
        check_eq("basic_mid_valid", 32'(out_valid2), 32'd0);
        tick();
        check_eq("basic_valid", 32'(out_valid2), 32'd1);
        check_eq("basic_data", 32'(out_data2), 32'h2211);
        check_eq("basic_bytes", 32'(out_bytes2), 32'd2);
        tick();
        check_eq("basic_accept", 32'(out_valid2), 32'd0);
        check_eq("basic_pops", 32'(pops2), 32'd2);

        // Backpressure
        out_ready2 = 1'b0;
        q2.push_back(8'h11); q2.push_back(8'h22); q2.push_back(8'h33);
        refresh();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp_data_%0d", i), 32'(out_data2), 32'h2211);
            check_eq($sformatf("bp_rinc_%0d", i), 32'(rinc2), 32'd0);
            tick();
        end
        check_eq("bp_left", 32'(q2.size()), 32'd1);
        out_ready2 = 1'b1;
        tick();
        check_eq("bp_acc_valid", 32'(out_valid2), 32'd0);
        check_eq("bp_acc_rinc", 32'(rinc2), 32'd1);
        check_eq("bp_acc_pops", 32'(pops2), 32'd4);
        tick();
        check_eq("bp_pop33", 32'(pops2), 32'd5);
        flush2 = 1'b1;
        tick();
        flush2 = 1'b0;
        check_eq("bp_tail_data", 32'(out_data2), 32'h0033);
        check_eq("bp_tail_bytes", 32'(out_bytes2), 32'd1);
        tick();

        // Flush of a single byte
        out_ready2 = 1'b0;
        q2.push_back(8'hA5);
        refresh();
        tick();
        check_eq("fl_nohold", 32'(out_valid2), 32'd0);
        flush2 = 1'b1;
        tick();
        flush2 = 1'b0;
        check_eq("fl_valid", 32'(out_valid2), 32'd1);
        check_eq("fl_data", 32'(out_data2), 32'h00A5);
        check_eq("fl_bytes", 32'(out_bytes2), 32'd1);
        out_ready2 = 1'b1;
        tick();
        check_eq("fl_accept", 32'(out_valid2), 32'd0);

        // Flush with nothing stored and FIFO empty: no zero-length word
        flush2 = 1'b1;
        tick();
        tick();
        check_eq("fl_empty_valid", 32'(out_valid2), 32'd0);
        check_eq("fl_empty_bytes", 32'(out_bytes2), 32'd0);
        flush2 = 1'b0;

        // PACK_N=4: flush coinciding with a pop
        out_ready4 = 1'b0;
        q4.push_back(8'h01); q4.push_back(8'h02);
        refresh();
        tick();
        tick();
        q4.push_back(8'h03);
        refresh();
        flush4 = 1'b1;
        tick();
        check_eq("sim_valid", 32'(out_valid4), 32'd1);
        check_eq("sim_data", out_data4, 32'h00030201);
        check_eq("sim_bytes", 32'(out_bytes4), 32'd3);
        tick();
        check_eq("sim_hold_data", out_data4, 32'h00030201);
        flush4 = 1'b0;
        out_ready4 = 1'b1;
        tick();
        check_eq("sim_accept", 32'(out_valid4), 32'd0);

        // PACK_N=4 full word
        q4.push_back(8'h11); q4.push_back(8'h22); q4.push_back(8'h33); q4.push_back(8'h44);
        refresh();
        for (int i = 0; i < 4; i++) tick();
        check_eq("full4_data", out_data4, 32'h44332211);
        check_eq("full4_bytes", 32'(out_bytes4), 32'd4);
        tick();
        check_eq("full4_pops", 32'(pops4), 32'd7);

        // Asynchronous reset while holding a word
        out_ready2 = 1'b0;
        q2.push_back(8'h5A); q2.push_back(8'hC3);
        refresh();
        tick();
        tick();
        check_eq("rh_valid_pre", 32'(out_valid2), 32'd1);
        #2 rrst_n = 1'b0;
        #1;
        check_eq("rh_valid_async", 32'(out_valid2), 32'd0);
        check_eq("rh_data_async", 32'(out_data2), 32'h0000);
        tick();
        rrst_n = 1'b1;

        // Stream 1024 incrementing bytes with random backpressure
        got2.delete();
        for (int i = 0; i < 1024; i++) q2.push_back(8'(i));
        refresh();
        budget = 0;
        while ((got2.size() < 512) && (budget < 8000)) begin
            out_ready2 = 1'($urandom_range(0, 1));
            tick();
            budget++;
        end
        out_ready2 = 1'b0;
        check_eq("stream_words", 32'(got2.size()), 32'd512);
        for (int i = 0; i < got2.size(); i++) begin
            base = 2 * i;
            w = got2[i];
            check_eq($sformatf("stream_w%0d", i), 32'(w), {14'd0, 2'd2, 8'(base + 1), 8'(base)});
        end
        tick();
        check_eq("stream_drained", 32'(q2.size()), 32'd0);
        check_eq("stream_no_extra", 32'(out_valid2), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
